mux_arb_nto1: RTL
=================

// Module: mux_arb_nto1
// PURPOSE
//   Parametrised N-channel, DATA_W-bit multiplexer with valid/ready handshake on every input and a
//   registered output stage. Picks one requesting channel per transfer: either by arbitration or by
//   a forced select. Sits wherever several producers share one consumer (bus funnels, debug taps).
//   One-deep output register gives full throughput with a 1-cycle latency.
// PARAMETERS
//   NUM_CH   8   number of input channels, >= 2
//   DATA_W   1   data width per channel, >= 1
//   SEL_W    $clog2(NUM_CH)  localparam, select/grant index width (min 1)
// PORTS
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous reset, active-high
//   in_data    in   NUM_CH*DATA_W   channel i at bits [i*DATA_W +: DATA_W]
//   in_valid   in   NUM_CH          channel i has data
//   in_ready   out  NUM_CH          channel i accepted this cycle (one-hot or zero)
//   force_en   in   1               1 = forced select mode, 0 = arbitrate
//   force_sel  in   SEL_W           channel used when force_en=1
//   out_data   out  DATA_W          registered selected data
//   out_valid  out  1               out_data holds a word
//   out_ready  in   1               consumer takes word when out_valid & out_ready
//   grant_idx  out  SEL_W           registered index of channel that sourced out_data
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): out_valid=0, out_data=0, grant_idx=0, arbiter pointer=0; in_ready
//     is 0 during any cycle rst=1. Reset mid-transfer drops the held word; no in_ready asserted.
//   - load_en = !out_valid | out_ready (register empty or draining this cycle).
//   - Winner (combinational): force_en=1 -> force_sel if in_valid[force_sel] and force_sel<NUM_CH,
//     else none. force_en=0 -> arbitration per CONFIGURATION.
//   - in_ready[w]=load_en for winner w only; all other bits 0. Transfer = in_valid[w]&in_ready[w].
//   - On transfer: out_data<=in_data[w], grant_idx<=w, out_valid<=1; latency exactly 1 cycle.
//   - load_en & no winner: out_valid<=0 (if draining); out_data/grant_idx hold.
//   - out_valid & !out_ready: out_data, grant_idx, out_valid held stable; all in_ready=0.
//   - Simultaneous drain+load: back-to-back, one word per cycle sustained.
//   - force_en may change any cycle; takes effect on the next winner selection, never on the held word.
// CONFIGURATION
//   MUX_ARB_RR_EN defined: round-robin. Pointer p (SEL_W bits); winner = first valid index searching
//     p, p+1, ... NUM_CH-1, 0, ... (wraps). On each arbitrated transfer p<=w+1 (wraps NUM_CH-1 -> 0).
//     Forced transfers do not move p.
//   MUX_ARB_RR_EN undefined: fixed priority, lowest valid index wins; no pointer register.
// STRUCTURE
//   - Package mux_pkg: function sel_width(n) (clog2, min 1), localparam-free mode encoding
//     typedef enum logic {MODE_ARB, MODE_FORCE} mux_mode_e.
//   - One sub-module: mux_rr_arbiter (NUM_CH req in, one-hot gnt + index out, advance input; pointer
//     present only under MUX_ARB_RR_EN, priority encoder otherwise). Datapath mux and output
//     register stay in mux_arb_nto1.
// TESTING
//   - Reset: rst=1 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout.
//   - NUM_CH=8,DATA_W=8, in_valid=8'h14 (ch2,ch4), out_ready=1 -> fixed: ch2 every cycle; with
//     MUX_ARB_RR_EN: grant_idx 2,4,2,4 on consecutive cycles, out_data matches channel data.
//   - Backpressure: word from ch3 loaded, out_ready=0 5 cycles -> out_data/grant_idx constant,
//     in_ready=8'h00; out_ready=1 -> next word loaded same cycle, no gap, no duplicate.
//   - Forced: force_en=1, force_sel=5, in_valid=8'hFF -> only in_ready[5] asserts, grant_idx=5;
//     in_valid[5]=0 -> out_valid drops after drain, in_ready=0.
//   - RR wrap: pointer at 7, in_valid=8'h81 -> grant 7 then 0 then 7; reset mid-burst -> next grant 0.
//   - Random: 10k cycles random valid/ready/force vs. scoreboard model; no loss, no duplication, order
//     per channel preserved.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 arbitrated mux.
// Round-robin arbitration is enabled by MUX_ARB_RR_EN.
package mux_pkg;

  typedef enum logic {
    MODE_ARB,
    MODE_FORCE
  } mux_mode_e;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_nto1_if.sv
// Channel and output handshake bundle for mux_arb_nto1.
// Round-robin arbitration is enabled by MUX_ARB_RR_EN.
interface mux_arb_nto1_if
  import mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1
);

  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic                     force_en;
  logic [SEL_W-1:0]         force_sel;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         grant_idx;

  modport master (
    output in_data,
    output in_valid,
    output force_en,
    output force_sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  grant_idx
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  force_en,
    input  force_sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output grant_idx
  );

endinterface

// File: rtl/mux_rr_arbiter.sv
// Request arbiter: round-robin when MUX_ARB_RR_EN is defined,
// fixed lowest-index priority otherwise.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
`ifdef MUX_ARB_RR_EN
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
`endif
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

`ifdef MUX_ARB_RR_EN

  logic [SEL_W-1:0] ptr;

  // first requester at or after ptr, wrapping past the top
  always_comb begin
    int ci;
    logic [SEL_W-1:0] c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    ci  = 0;
    c   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ci = int'(ptr) + k;
      if (ci >= NUM_CH) ci = ci - NUM_CH;
      c = SEL_W'(ci);
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = c;
        gnt[c] = 1'b1;
      end
    end
  end

  // step past the granted channel after an arbitrated transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      if (int'(idx) == NUM_CH - 1) ptr <= '0;
      else                         ptr <= idx + 1'b1;
    end
  end

`else

  // lowest requesting index wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = SEL_W'(i);
        any    = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mux_arb_nto1.sv
// N-channel valid/ready mux with forced select and a one-deep
// output register. Round-robin when MUX_ARB_RR_EN is defined.
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1
) (
  input logic           clk,
  input logic           rst,
  mux_arb_nto1_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_CH);

  mux_mode_e         mode;
  logic              load_en;
  logic              xfer;
  logic              win_any;
  logic [SEL_W-1:0]  win_idx;
  logic [NUM_CH-1:0] win_gnt;
  logic              arb_any;
  logic [SEL_W-1:0]  arb_idx;
  logic [NUM_CH-1:0] arb_gnt;
  logic              frc_any;
  logic [NUM_CH-1:0] frc_gnt;
  logic [DATA_W-1:0] sel_data;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  grant_q;
`ifdef MUX_ARB_RR_EN
  logic              advance;
`endif

  assign mode    = bus.force_en ? MODE_FORCE : MODE_ARB;
  assign load_en = !valid_q || bus.out_ready;

  mux_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
`ifdef MUX_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
`endif
    .req     (bus.in_valid),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  // forced channel wins only if it exists and is requesting
  always_comb begin
    frc_any = 1'b0;
    frc_gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.force_sel == SEL_W'(i) && bus.in_valid[i]) begin
        frc_any    = 1'b1;
        frc_gnt[i] = 1'b1;
      end
    end
  end

  // pick the winner for this cycle from the active mode
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_gnt = '0;
    unique case (mode)
      MODE_FORCE: begin
        win_any = frc_any;
        win_idx = bus.force_sel;
        win_gnt = frc_gnt;
      end
      MODE_ARB: begin
        win_any = arb_any;
        win_idx = arb_idx;
        win_gnt = arb_gnt;
      end
    endcase
  end

  assign xfer         = win_any && load_en && !rst;
  assign bus.in_ready = xfer ? win_gnt : '0;

`ifdef MUX_ARB_RR_EN
  assign advance = xfer && (mode == MODE_ARB);
`endif

  // route the winning channel's word to the register input
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_idx == SEL_W'(i)) begin
        sel_data = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // output register: load on transfer, empty on drain with no winner
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else if (load_en) begin
      if (xfer) begin
        valid_q <= 1'b1;
        data_q  <= sel_data;
        grant_q <= win_idx;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.grant_idx = grant_q;

endmodule
